// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared definitions for the motor PWM path.
//   - hb_state_t   : H-bridge FSM state encoding (2 bits)
//   - DEFAULT_*    : PWM period, duty clamp and dead time, shared with the
//                    controllers' clamp limits
//   - clamp_duty   : saturate a signed command to +/-limit
//   - dir_of       : map a signed duty to its drive direction state
package motor_pwm_pkg;

    localparam int unsigned DEFAULT_PERIOD      = 4000;  // 25 kHz at 100 MHz
    localparam int unsigned DEFAULT_MAX_DUTY    = 4000;
    localparam int unsigned DEFAULT_DEAD_CYCLES = 100;   // 1 us

    typedef enum logic [1:0] {
        S_ZERO = 2'd0,
        S_FWD  = 2'd1,
        S_REV  = 2'd2,
        S_DEAD = 2'd3
    } hb_state_t;

    // -32768 has no positive twin, so it simply lands on -lim like any
    // other out-of-range negative command.
    function automatic logic signed [15:0] clamp_duty(input logic signed [15:0] cmd,
                                                      input logic signed [15:0] lim);
        if (cmd > lim)
            return lim;
        else if (cmd < -lim)
            return -lim;
        else
            return cmd;
    endfunction

    function automatic hb_state_t dir_of(input logic signed [15:0] duty);
        if (duty == '0)
            return S_ZERO;
        else if (duty[15])
            return S_REV;
        else
            return S_FWD;
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running PWM period counter.
//   clk, reset_n  : system clock, asynchronous active-low reset
//   cnt           : 0..PERIOD-1, wraps to 0
//   load_strobe   : combinational, high while cnt == PERIOD-1 (shadow load)
//   period_start  : registered pulse aligned with the first registered
//                   output cycle of each period (two cycles after the strobe)
module pwm_period_timer
    import motor_pwm_pkg::*;
#(
    parameter int unsigned PERIOD = DEFAULT_PERIOD
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic [$clog2(PERIOD)-1:0]   cnt,
    output logic                        load_strobe,
    output logic                        period_start
);

    localparam int unsigned   CW   = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic wrap_q;

    assign load_strobe = (cnt == LAST);

    // Outputs lag the cnt compare by one cycle, so the period marker is
    // delayed once more past the wrap to line up with pwm_in1/pwm_in2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            wrap_q       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= load_strobe ? '0 : cnt + CW'(1);
            wrap_q       <= load_strobe;
            period_start <= wrap_q;
        end
    end

endmodule

// File: rtl/hbridge_pwm_driver.sv
// hbridge_pwm_driver: signed motor command -> IN1/IN2 H-bridge PWM pair.
//   clk, reset_n   : 100 MHz system clock, asynchronous active-low reset
//   enable         : low forces outputs off, FSM to S_ZERO, clears fault latch
//   fault_n        : active-low driver fault (already synchronised)
//   duty_cmd       : signed command, sampled only at the period boundary
//   pwm_in1/in2    : registered forward/reverse drive outputs
//   period_start   : pulse on the first output cycle of each period
//   duty_applied   : clamped duty in effect for the current period
//   fault_latched  : sticky fault flag
// Build option HBRIDGE_PWM_BRAKE_EN: S_ZERO drives 1/1 (slow-decay brake)
// and entry/exit of S_ZERO passes through S_DEAD; otherwise S_ZERO coasts
// (0/0) and ZERO transitions are direct.
module hbridge_pwm_driver
    import motor_pwm_pkg::*;
#(
    parameter int unsigned PERIOD      = DEFAULT_PERIOD,
    parameter int unsigned MAX_DUTY    = DEFAULT_MAX_DUTY,
    parameter int unsigned DEAD_CYCLES = DEFAULT_DEAD_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               fault_n,
    input  logic signed [15:0] duty_cmd,
    output logic               pwm_in1,
    output logic               pwm_in2,
    output logic               period_start,
    output logic signed [15:0] duty_applied,
    output logic               fault_latched
);

    localparam int unsigned      CW        = $clog2(PERIOD);
    localparam logic signed [15:0] DUTY_LIM = 16'(MAX_DUTY);
    localparam logic [CW-1:0]    DEAD_LAST = CW'(DEAD_CYCLES - 1);

`ifdef HBRIDGE_PWM_BRAKE_EN
    localparam logic BRAKE = 1'b1;
`else
    localparam logic BRAKE = 1'b0;
`endif

    logic [CW-1:0]      cnt;
    logic               load_strobe;
    hb_state_t          state, state_nxt, tgt;
    logic signed [15:0] duty_clamped, duty_nxt;
    logic [15:0]        mag;
    logic               active, kill;
    logic               in1_nxt, in2_nxt;

    pwm_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .cnt          (cnt),
        .load_strobe  (load_strobe),
        .period_start (period_start)
    );

    // fault_n is folded in directly so the outputs drop on the very next
    // edge, before the latch itself has updated.
    assign kill   = !enable || fault_latched || !fault_n;
    assign mag    = duty_applied[15] ? 16'(-duty_applied) : 16'(duty_applied);
    assign active = 16'(cnt) < mag;

    always_comb begin
        duty_clamped = clamp_duty(duty_cmd, DUTY_LIM);
        tgt          = dir_of(duty_clamped);
        state_nxt    = state;
        duty_nxt     = duty_applied;
        if (kill) begin
            state_nxt = S_ZERO;
            duty_nxt  = '0;
        end else if (load_strobe) begin
            duty_nxt = duty_clamped;
            if (state != S_DEAD && tgt != state) begin
                // FWD<->REV always needs dead time; a move touching S_ZERO
                // needs it only when S_ZERO actively brakes.
                if (BRAKE || (state != S_ZERO && tgt != S_ZERO))
                    state_nxt = S_DEAD;
                else
                    state_nxt = tgt;
            end
        end else if (state == S_DEAD && cnt == DEAD_LAST) begin
            state_nxt = dir_of(duty_applied);
        end
    end

    always_comb begin
        in1_nxt = 1'b0;
        in2_nxt = 1'b0;
        if (!kill) begin
            case (state)
                S_FWD:   in1_nxt = active;
                S_REV:   in2_nxt = active;
                S_ZERO: begin
                    in1_nxt = BRAKE;
                    in2_nxt = BRAKE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_ZERO;
            duty_applied  <= '0;
            pwm_in1       <= 1'b0;
            pwm_in2       <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state        <= state_nxt;
            duty_applied <= duty_nxt;
            pwm_in1      <= in1_nxt;
            pwm_in2      <= in2_nxt;
            if (!enable)
                fault_latched <= 1'b0;
            else if (!fault_n)
                fault_latched <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// tb_hbridge_pwm_driver: directed bench for hbridge_pwm_driver.
// Expected per-period results (high counts, overlap, leading dead cycles,
// applied duty) are queued when the command is driven and compared when the
// period is observed. Honors HBRIDGE_PWM_BRAKE_EN for S_ZERO expectations.
`timescale 1ns/1ps
module tb_hbridge_pwm_driver;

    localparam int PER  = 4000;

`ifdef HBRIDGE_PWM_BRAKE_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               fault_n;
    logic signed [15:0] duty_cmd;
    logic               pwm_in1;
    logic               pwm_in2;
    logic               period_start;
    logic signed [15:0] duty_applied;
    logic               fault_latched;

    hbridge_pwm_driver #(
        .PERIOD      (4000),
        .MAX_DUTY    (4000),
        .DEAD_CYCLES (100)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .fault_n       (fault_n),
        .duty_cmd      (duty_cmd),
        .pwm_in1       (pwm_in1),
        .pwm_in2       (pwm_in2),
        .period_start  (period_start),
        .duty_applied  (duty_applied),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    in1;
        int    in2;
        int    ov;
        int    lead;
        int    duty;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    task automatic push_exp(input string tag, input int in1, input int in2,
                            input int ov, input int lead, input int duty);
        exp_t e;
        e.tag = tag; e.in1 = in1; e.in2 = in2; e.ov = ov; e.lead = lead; e.duty = duty;
        sb.push_back(e);
    endtask

    // Count period_start latency in clk cycles from the current negedge.
    task automatic wait_ps(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 3 * PER);
        if (!period_start) k = -1;
    endtask

    // Called on the negedge where period_start is high; observes one full
    // output period. act_kind: 0 none, 1 set duty_cmd, 2 one-cycle fault
    // pulse, 3 one-cycle enable drop, all applied after sample act_idx.
    task automatic measure_period(input int act_idx, input int act_kind, input int act_val);
        int   n1 = 0, n2 = 0, nov = 0, lead = -1, d;
        exp_t e;
        d = int'(duty_applied);
        for (int i = 0; i < PER; i++) begin
            if (pwm_in1) n1++;
            if (pwm_in2) n2++;
            if (pwm_in1 && pwm_in2) nov++;
            if (lead < 0 && (pwm_in1 || pwm_in2)) lead = i;
            if (i == act_idx) begin
                case (act_kind)
                    1: duty_cmd = 16'(act_val);
                    2: fault_n  = 1'b0;
                    3: enable   = 1'b0;
                    default: ;
                endcase
            end
            if (act_kind >= 2 && i == act_idx + 1) begin
                fault_n = 1'b1;
                enable  = 1'b1;
            end
            @(negedge clk);
        end
        if (lead < 0) lead = PER;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_period_start"}, period_start, 1);
            check({e.tag, "_in1_high"}, n1, e.in1);
            check({e.tag, "_in2_high"}, n2, e.in2);
            check({e.tag, "_overlap"}, nov, e.ov);
            check({e.tag, "_lead_low"}, lead, e.lead);
            check({e.tag, "_duty_applied"}, d, e.duty);
        end
    endtask

    initial begin
        int k;
        reset_n  = 1'b0;
        enable   = 1'b0;
        fault_n  = 1'b1;
        duty_cmd = '0;
        repeat (3) @(negedge clk);
        check("rst_in1", pwm_in1, 0);
        check("rst_in2", pwm_in2, 0);
        check("rst_period_start", period_start, 0);
        check("rst_duty_applied", duty_applied, 0);
        check("rst_fault_latched", fault_latched, 0);

        reset_n  = 1'b1;
        enable   = 1'b1;
        duty_cmd = 16'sd1000;
        wait_ps(k);
        check("first_ps_latency", k, PER + 1);

        if (BRK) push_exp("p1_fwd1000", 900, 0, 0, 100, 1000);
        else     push_exp("p1_fwd1000", 1000, 0, 0, 0, 1000);
        measure_period(-1, 0, 0);
        push_exp("p2_fwd1000", 1000, 0, 0, 0, 1000);
        measure_period(-1, 0, 0);
        // change at the very start of the period must wait for the boundary
        push_exp("p3_ignore_mid", 1000, 0, 0, 0, 1000);
        measure_period(0, 1, 2000);
        push_exp("p4_fwd2000", 2000, 0, 0, 0, 2000);
        measure_period(2000, 1, -2000);
        push_exp("p5_rev_dead", 0, 1900, 0, 100, -2000);
        measure_period(300, 1, 5000);
        push_exp("p6_clamp_pos", 3900, 0, 0, 100, 4000);
        measure_period(300, 1, -32768);
        push_exp("p7_clamp_neg", 0, 3900, 0, 100, -4000);
        measure_period(-1, 0, 0);
        push_exp("p8_full_rev", 0, 4000, 0, 0, -4000);
        measure_period(300, 1, 0);
        if (BRK) push_exp("p9_zero", 3900, 3900, 3900, 100, 0);
        else     push_exp("p9_zero", 0, 0, 0, PER, 0);
        measure_period(300, 1, 3000);
        if (BRK) push_exp("p10_fwd3000", 2900, 0, 0, 100, 3000);
        else     push_exp("p10_fwd3000", 3000, 0, 0, 0, 3000);
        measure_period(-1, 0, 0);
        push_exp("p11_fault", 500, 0, 0, 0, 3000);
        measure_period(499, 2, 0);
        check("fault_latched_set", fault_latched, 1);
        if (BRK) push_exp("p12_faulted", 2998, 2998, 2998, 1002, 0);
        else     push_exp("p12_faulted", 0, 0, 0, PER, 0);
        measure_period(1000, 3, 0);
        check("fault_latched_cleared", fault_latched, 0);
        if (BRK) push_exp("p13_resume", 2900, 0, 0, 100, 3000);
        else     push_exp("p13_resume", 3000, 0, 0, 0, 3000);
        measure_period(-1, 0, 0);

        repeat (1500) @(negedge clk);
        check("pre_reset_in1", pwm_in1, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_in1", pwm_in1, 0);
        check("midrst_in2", pwm_in2, 0);
        check("midrst_period_start", period_start, 0);
        check("midrst_duty_applied", duty_applied, 0);
        check("midrst_fault_latched", fault_latched, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_ps(k);
        check("post_reset_ps_latency", k, PER + 1);
        if (BRK) push_exp("p14_after_reset", 2900, 0, 0, 100, 3000);
        else     push_exp("p14_after_reset", 3000, 0, 0, 0, 3000);
        measure_period(-1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
